control_config_cursor: RTL and testbench
========================================

CONTROL_CONFIG_CURSOR -- requirements
Module: control_config_cursor

Interface
REQ-001 The block SHALL have parameter BLINK_HALF, default 25_000_000, meaning clk cycles per parpadeo half-period (0.5 s at 50 MHz).
REQ-002 The block SHALL have parameter IDLE_HALVES, default 20, meaning blink half-periods without a button press before automatic exit from configuration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_mode, input, 1 bit: one-cycle debounced pulse that advances the configuration mode.
REQ-006 The block SHALL have port btn_left, input, 1 bit: one-cycle pulse that moves the cursor left (cursor_location +1).
REQ-007 The block SHALL have port btn_right, input, 1 bit: one-cycle pulse that moves the cursor right (cursor_location -1).
REQ-008 The block SHALL have port btn_exit, input, 1 bit: one-cycle pulse that forces the normal mode.
REQ-009 The block SHALL have port config_mode, output, 2 bits: 0 normal, 1 time config, 2 date config, 3 timer config.
REQ-010 The block SHALL have port cursor_location, output, 2 bits: 0 right pair, 1 middle pair, 2 left pair, 3 AM/PM or weekday field.
REQ-011 The block SHALL have port parpadeo, output, 1 bit: cursor blink phase; 1 means the cursor is shown.
REQ-012 The block SHALL have port mode_change, output, 1 bit: one-cycle pulse whenever config_mode changes value.

Function
REQ-013 All outputs SHALL be registered, and each SHALL update on the clk edge after the causing input pulse (1-cycle latency).
REQ-014 The FSM SHALL have four states, NORMAL, CFG_HORA, CFG_FECHA and CFG_TIMER, whose encodings equal the config_mode values 0 to 3.
REQ-015 btn_mode SHALL move the FSM NORMAL -> CFG_HORA -> CFG_FECHA -> CFG_TIMER -> NORMAL.
REQ-016 btn_exit SHALL move the FSM to NORMAL from any state; in NORMAL it SHALL have no effect and SHALL NOT pulse mode_change.
REQ-017 The maximum cursor value SHALL be 3 in CFG_HORA, 3 in CFG_FECHA and 2 in CFG_TIMER; in NORMAL the cursor SHALL be held at 0.
REQ-018 btn_left at the maximum cursor value SHALL wrap the cursor to 0, and btn_right at 0 SHALL wrap it to the maximum value.
REQ-019 On every mode change the cursor SHALL reset to 0.
REQ-020 Priority for simultaneous pulses SHALL be btn_exit > btn_mode > cursor buttons.
REQ-021 btn_left and btn_right asserted together SHALL be ignored.
REQ-022 Cursor buttons SHALL be ignored in NORMAL.
REQ-023 In NORMAL, parpadeo SHALL be 0 and the blink counter SHALL be held at 0.
REQ-024 In any CFG state, parpadeo SHALL toggle each time the blink counter reaches BLINK_HALF-1, after which the counter wraps to 0.
REQ-025 On entry to any CFG state, and on any accepted cursor move, the counter SHALL restart at 0 and parpadeo SHALL be forced to 1 (cursor immediately visible).
REQ-026 The idle counter SHALL count blink half-periods in CFG states and SHALL clear on any button pulse.
REQ-027 When the idle counter reaches IDLE_HALVES, the FSM SHALL go to NORMAL with a mode_change pulse.
REQ-028 The blink counter width SHALL be $clog2(BLINK_HALF); no counter SHALL overflow silently.

Reset
REQ-029 When reset is high, asynchronously: config_mode=0, cursor_location=0, parpadeo=0, mode_change=0, and all counters=0.
REQ-030 Reset asserted mid-configuration SHALL abort to NORMAL without a mode_change pulse.
REQ-031 Operation SHALL resume on the first clk edge after reset deasserts.

Structure
REQ-032 The shared package SHALL hold the mode encodings (MODE_NORMAL, MODE_HORA, MODE_FECHA, MODE_TIMER) and the per-mode maximum cursor constants.
REQ-033 The blink and idle timing SHALL be one sub-module, temporizador_parpadeo (inputs enable and restart; outputs parpadeo and a half-period tick); the FSM and cursor logic SHALL be in the top module.

Verification (BLINK_HALF=4, IDLE_HALVES=3)
REQ-034 Scenario: reset, then btn_mode x4 -> config_mode 1,2,3,0 on successive pulses, mode_change high one cycle after each pulse, cursor_location=0 throughout.
REQ-035 Scenario: in CFG_TIMER, btn_left x3 -> cursor_location 1,2,0; then btn_right -> 2.
REQ-036 Scenario: in CFG_FECHA with cursor=3, btn_left -> cursor=0; btn_left and btn_right in the same cycle -> no change; btn_exit and btn_mode in the same cycle -> config_mode=0.
REQ-037 Scenario: enter CFG_HORA -> parpadeo=1 for 4 cycles, 0 for 4 cycles, and so on; a btn_left mid-low-phase -> parpadeo=1 on the next cycle and the phase restarts.
REQ-038 Scenario: enter CFG_HORA and apply no buttons -> config_mode returns to 0 after 3 half-periods (12 cycles) with a mode_change pulse.
REQ-039 Scenario: reset asserted in CFG_FECHA with cursor=2 -> all outputs 0 immediately, before any clk edge.

Source files
------------

// File: rtl/control_config_cursor_pkg.sv
// Shared mode encodings and per-mode cursor limits for the configuration cursor block.
package control_config_cursor_pkg;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_HORA   = 2'd1;
  localparam logic [1:0] MODE_FECHA  = 2'd2;
  localparam logic [1:0] MODE_TIMER  = 2'd3;

  localparam logic [1:0] MAX_CURSOR_HORA  = 2'd3;
  localparam logic [1:0] MAX_CURSOR_FECHA = 2'd3;
  localparam logic [1:0] MAX_CURSOR_TIMER = 2'd2;

  typedef enum logic [1:0] {
    NORMAL    = MODE_NORMAL,
    CFG_HORA  = MODE_HORA,
    CFG_FECHA = MODE_FECHA,
    CFG_TIMER = MODE_TIMER
  } state_e;

  function automatic logic [1:0] max_cursor(input state_e s);
    case (s)
      CFG_HORA:  return MAX_CURSOR_HORA;
      CFG_FECHA: return MAX_CURSOR_FECHA;
      CFG_TIMER: return MAX_CURSOR_TIMER;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_config_cursor_temporizador_parpadeo.sv
// Cursor blink generator plus idle half-period counter used for the automatic
// exit from configuration.
module temporizador_parpadeo #(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int IDLE_HALVES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  input  logic clear_idle,
  output logic parpadeo,
  output logic half_tick,
  output logic idle_last
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(IDLE_HALVES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_HALVES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          par_q, par_d;
  logic          running_q, running_d;

  // Tick only from registered state so the top can feed its FSM decision
  // back into enable without a combinational loop.
  assign half_tick = running_q && (cnt_q == CNT_LAST);
  assign idle_last = (idle_q == IDLE_LAST);
  assign parpadeo  = par_q;

  always_comb begin
    cnt_d     = cnt_q;
    par_d     = par_q;
    idle_d    = idle_q;
    running_d = enable;
    if (!enable) begin
      cnt_d  = '0;
      par_d  = 1'b0;
      idle_d = '0;
    end else begin
      if (restart) begin
        cnt_d = '0;
        par_d = 1'b1;
      end else if (half_tick) begin
        cnt_d = '0;
        par_d = ~par_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (clear_idle) begin
        idle_d = '0;
      end else if (half_tick && !idle_last) begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      par_q     <= 1'b0;
      idle_q    <= '0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      idle_q    <= idle_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/control_config_cursor.sv
// Configuration-mode FSM and edit cursor for a clock/date/timer display, with
// blinking cursor and idle timeout back to normal mode.
module control_config_cursor
  import control_config_cursor_pkg::*;
#(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int IDLE_HALVES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_exit,
  output logic [1:0] config_mode,
  output logic [1:0] cursor_location,
  output logic       parpadeo,
  output logic       mode_change
);

  state_e     state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic       mode_change_q, mode_change_d;
  logic       any_btn, move, restart, enable;
  logic       half_tick, idle_last, timeout;
  logic [1:0] cmax;

  assign any_btn = btn_mode | btn_left | btn_right | btn_exit;
  assign timeout = half_tick && idle_last && !any_btn;
  assign cmax    = max_cursor(state_q);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    move     = 1'b0;
    if (btn_exit) begin
      state_d = NORMAL;
    end else if (btn_mode) begin
      case (state_q)
        NORMAL:    state_d = CFG_HORA;
        CFG_HORA:  state_d = CFG_FECHA;
        CFG_FECHA: state_d = CFG_TIMER;
        default:   state_d = NORMAL;
      endcase
    end else if (timeout) begin
      state_d = NORMAL;
    end else if (state_q != NORMAL && (btn_left ^ btn_right)) begin
      move = 1'b1;
      if (btn_left) begin
        cursor_d = (cursor_q >= cmax) ? 2'd0 : cursor_q + 2'd1;
      end else begin
        cursor_d = (cursor_q == 2'd0) ? cmax : cursor_q - 2'd1;
      end
    end
    if (state_d != state_q || state_d == NORMAL) begin
      cursor_d = 2'd0;
    end
    mode_change_d = (state_d != state_q);
    enable        = (state_d != NORMAL);
    restart       = move || (enable && state_d != state_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= NORMAL;
      cursor_q      <= 2'd0;
      mode_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      mode_change_q <= mode_change_d;
    end
  end

  temporizador_parpadeo #(
    .BLINK_HALF (BLINK_HALF),
    .IDLE_HALVES(IDLE_HALVES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .clear_idle(any_btn),
    .parpadeo  (parpadeo),
    .half_tick (half_tick),
    .idle_last (idle_last)
  );

  assign config_mode     = state_q;
  assign cursor_location = cursor_q;
  assign mode_change     = mode_change_q;

endmodule

// File: tb/tb_control_config_cursor.sv
// Directed bench for control_config_cursor with BLINK_HALF=4, IDLE_HALVES=3.
module tb_control_config_cursor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_exit = 1'b0;
  logic [1:0] config_mode, cursor_location;
  logic       parpadeo, mode_change;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_config_cursor #(.BLINK_HALF(4), .IDLE_HALVES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_mode       (btn_mode),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_exit       (btn_exit),
    .config_mode    (config_mode),
    .cursor_location(cursor_location),
    .parpadeo       (parpadeo),
    .mode_change    (mode_change)
  );

  typedef struct packed {
    logic [3:0] btns;   // {mode, left, right, exit}
    logic [1:0] mode;
    logic [1:0] cur;
    logic       par;
    logic       mc;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] b, input logic [1:0] m, input logic [1:0] c,
                              input logic p, input logic mc);
    vec_t v;
    v.btns = b; v.mode = m; v.cur = c; v.par = p; v.mc = mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [5:0] exp_v);
    logic [5:0] got;
    got = {config_mode, cursor_location, parpadeo, mode_change};
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got mode=%0d cur=%0d par=%0d mc=%0d, expected mode=%0d cur=%0d par=%0d mc=%0d",
               name, got[5:4], got[3:2], got[1], got[0], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end else begin
      $display("ok   %s: mode=%0d cur=%0d par=%0d mc=%0d", name, got[5:4], got[3:2], got[1], got[0]);
    end
  endtask

  // Called at a negedge: drive pulses for one edge, then return at the following negedge.
  task automatic step(input logic [3:0] b);
    {btn_mode, btn_left, btn_right, btn_exit} = b;
    @(posedge clk);
    #1;
    {btn_mode, btn_left, btn_right, btn_exit} = 4'b0000;
    @(negedge clk);
  endtask

  localparam logic [3:0] N = 4'b0000, M = 4'b1000, L = 4'b0100, R = 4'b0010, X = 4'b0001;

  logic [7:0] blink_exp;

  initial begin
    vecs[0]  = mk(N,     2'd0, 2'd0, 1'b0, 1'b0);
    vecs[1]  = mk(M,     2'd1, 2'd0, 1'b1, 1'b1);
    vecs[2]  = mk(M,     2'd2, 2'd0, 1'b1, 1'b1);
    vecs[3]  = mk(M,     2'd3, 2'd0, 1'b1, 1'b1);
    vecs[4]  = mk(M,     2'd0, 2'd0, 1'b0, 1'b1);
    vecs[5]  = mk(N,     2'd0, 2'd0, 1'b0, 1'b0);
    vecs[6]  = mk(X,     2'd0, 2'd0, 1'b0, 1'b0);
    vecs[7]  = mk(L,     2'd0, 2'd0, 1'b0, 1'b0);
    vecs[8]  = mk(M,     2'd1, 2'd0, 1'b1, 1'b1);
    vecs[9]  = mk(M,     2'd2, 2'd0, 1'b1, 1'b1);
    vecs[10] = mk(M,     2'd3, 2'd0, 1'b1, 1'b1);
    vecs[11] = mk(L,     2'd3, 2'd1, 1'b1, 1'b0);
    vecs[12] = mk(L,     2'd3, 2'd2, 1'b1, 1'b0);
    vecs[13] = mk(L,     2'd3, 2'd0, 1'b1, 1'b0);
    vecs[14] = mk(R,     2'd3, 2'd2, 1'b1, 1'b0);
    vecs[15] = mk(N,     2'd3, 2'd2, 1'b1, 1'b0);
    vecs[16] = mk(N,     2'd3, 2'd2, 1'b1, 1'b0);
    vecs[17] = mk(N,     2'd3, 2'd2, 1'b1, 1'b0);
    vecs[18] = mk(N,     2'd3, 2'd2, 1'b0, 1'b0);
    vecs[19] = mk(R,     2'd3, 2'd1, 1'b1, 1'b0);
    vecs[20] = mk(M,     2'd0, 2'd0, 1'b0, 1'b1);
    vecs[21] = mk(M,     2'd1, 2'd0, 1'b1, 1'b1);
    vecs[22] = mk(M,     2'd2, 2'd0, 1'b1, 1'b1);
    vecs[23] = mk(R,     2'd2, 2'd3, 1'b1, 1'b0);
    vecs[24] = mk(L,     2'd2, 2'd0, 1'b1, 1'b0);
    vecs[25] = mk(L | R, 2'd2, 2'd0, 1'b1, 1'b0);
    vecs[26] = mk(X | M, 2'd0, 2'd0, 1'b0, 1'b1);
    vecs[27] = mk(X,     2'd0, 2'd0, 1'b0, 1'b0);
    vecs[28] = mk(M | L, 2'd1, 2'd0, 1'b1, 1'b1);
    vecs[29] = mk(X | L, 2'd0, 2'd0, 1'b0, 1'b1);

    #1;
    check("reset_state", 6'b000000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_release", 6'b000000);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].btns);
      check($sformatf("vec%0d", i), {vecs[i].mode, vecs[i].cur, vecs[i].par, vecs[i].mc});
    end

    // Blink phase and restart on a cursor move, then idle timeout.
    step(M);
    check("blink_enter", {2'd1, 2'd0, 1'b1, 1'b1});
    blink_exp = 8'b11100000; // par after the 5 idle edges that follow entry (msb first)
    for (int i = 0; i < 5; i++) begin
      step(N);
      check($sformatf("blink_e%0d", i + 1), {2'd1, 2'd0, blink_exp[7 - i], 1'b0});
    end
    step(L);
    check("blink_restart", {2'd1, 2'd1, 1'b1, 1'b0});
    for (int i = 7; i <= 17; i++) begin
      step(N);
      check($sformatf("blink_e%0d", i), {2'd1, 2'd1, (i <= 9 || i >= 14) ? 1'b1 : 1'b0, 1'b0});
    end
    step(N);
    check("idle_exit_after_move", {2'd0, 2'd0, 1'b0, 1'b1});
    step(N);
    check("idle_exit_mc_clear", 6'b000000);

    // Pure idle timeout: 12 cycles after entry.
    step(M);
    check("idle_enter", {2'd1, 2'd0, 1'b1, 1'b1});
    for (int i = 1; i <= 11; i++) begin
      step(N);
      check($sformatf("idle_e%0d", i), {2'd1, 2'd0, (i >= 4 && i <= 7) ? 1'b0 : 1'b1, 1'b0});
    end
    step(N);
    check("idle_timeout", {2'd0, 2'd0, 1'b0, 1'b1});

    // Asynchronous reset in CFG_FECHA with cursor 2.
    step(M);
    step(M);
    step(L);
    step(L);
    check("pre_reset", {2'd2, 2'd2, 1'b1, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 6'b000000);
    btn_mode = 1'b1;
    @(negedge clk);
    check("reset_held", 6'b000000);
    btn_mode = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_released", 6'b000000);
    step(M);
    check("resume", {2'd1, 2'd0, 1'b1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
